// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving an icache (r0) and a dcache (r1) turns at one memory port.
// Ports: clk/reset; per requester rN_req/we/addr/wdata in, rN_gnt/rvalid/beat/done out;
// shared rdata; memory side mem_req/we/addr/wdata out, mem_rdata/mem_ack in.
module mem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BEATS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic [AW-1:0]            r0_addr,
  input  logic [DW-1:0]            r0_wdata,
  output logic                     r0_gnt,
  output logic                     r0_rvalid,
  output logic [$clog2(BEATS)-1:0] r0_beat,
  output logic                     r0_done,
  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic [AW-1:0]            r1_addr,
  input  logic [DW-1:0]            r1_wdata,
  output logic                     r1_gnt,
  output logic                     r1_rvalid,
  output logic [$clog2(BEATS)-1:0] r1_beat,
  output logic                     r1_done,
  output logic [DW-1:0]            rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_ack
);
  localparam int BW = $clog2(BEATS);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          pick, access, rd_ack;
  // on a tie the requester not served last wins; otherwise whoever asks
  assign pick   = (r0_req && r1_req) ? ~last_q : r1_req;
  assign access = state_q == ACCESS;
  assign rd_ack = access && !we_q && mem_ack;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    if (state_q == IDLE && (r0_req || r1_req)) begin
      state_d = ACCESS;
      owner_d = pick;
      last_d  = pick;
      we_d    = pick ? r1_we : r0_we;
      addr_d  = pick ? r1_addr : r0_addr;
      wdata_d = pick ? r1_wdata : r0_wdata;
      beat_d  = '0;
    end else if (access && mem_ack) begin
      beat_d  = we_q ? beat_q : beat_q + BW'(1);
      state_d = (we_q || beat_q == BW'(BEATS - 1)) ? RELEASE : ACCESS;
    end else if (state_q == RELEASE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
    end
  end
  assign r0_gnt    = state_q != IDLE && !owner_q;
  assign r1_gnt    = state_q != IDLE && owner_q;
  assign r0_rvalid = rd_ack && !owner_q;
  assign r1_rvalid = rd_ack && owner_q;
  assign r0_beat   = r0_rvalid ? beat_q : '0;
  assign r1_beat   = r1_rvalid ? beat_q : '0;
  assign r0_done   = state_q == RELEASE && !owner_q;
  assign r1_done   = state_q == RELEASE && owner_q;
  assign rdata     = rd_ack ? mem_rdata : '0;
  assign mem_req   = access;
  assign mem_we    = access && we_q;
  // refills walk an aligned BEATS-word block starting at word 0
  assign mem_addr  = !access ? '0 : we_q ? addr_q :
                     (addr_q & ~AW'(4 * BEATS - 1)) + AW'({beat_q, 2'b00});
  assign mem_wdata = access ? wdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int BEATS = 4;
  logic        clk = 0, reset;
  logic        r0_req, r0_we, r1_req, r1_we, mem_ack;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, mem_rdata;
  logic        r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done;
  logic [1:0]  r0_beat, r1_beat;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  int          n_vec = 0, n_err = 0;
  int          m_owner, m_last, m_words;
  bit          m_rel, m_we;
  logic [31:0] m_addr, m_wdata;

  mem_arbiter #(.AW(32), .DW(32), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_beat(r0_beat), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_beat(r1_beat), .r1_done(r1_done),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_words = 0; m_rel = 0; m_we = 0;
  endtask

  task automatic compare();
    bit acc, rv;
    acc = m_owner >= 0 && !m_rel;
    rv  = acc && !m_we && mem_ack;
    check("r0_gnt", r0_gnt, m_owner == 0);
    check("r1_gnt", r1_gnt, m_owner == 1);
    check("r0_rvalid", r0_rvalid, rv && m_owner == 0);
    check("r1_rvalid", r1_rvalid, rv && m_owner == 1);
    check("r0_done", r0_done, m_rel && m_owner == 0);
    check("r1_done", r1_done, m_rel && m_owner == 1);
    check("mem_req", mem_req, acc);
    check("mem_we", mem_we, acc && m_we);
    if (acc) check("mem_addr", mem_addr,
                   m_we ? m_addr : m_addr - (m_addr % (4 * BEATS)) + 32'(4 * m_words));
    if (acc && m_we) check("mem_wdata", mem_wdata, m_wdata);
    if (rv) begin
      check("rdata", rdata, mem_rdata);
      check("beat", m_owner == 0 ? r0_beat : r1_beat, m_words);
    end
  endtask

  task automatic model_step();
    int n;
    if (m_rel) begin
      m_owner = -1; m_rel = 0;
    end else if (m_owner >= 0) begin
      if (mem_ack) begin
        if (m_we) m_rel = 1;
        else begin
          m_words++;
          if (m_words == BEATS) begin m_rel = 1; m_words = 0; end
        end
      end
    end else if (r0_req || r1_req) begin
      n = (r0_req && r1_req) ? 1 - m_last : (r1_req ? 1 : 0);
      m_owner = n; m_last = n; m_words = 0;
      m_we    = n ? r1_we : r0_we;
      m_addr  = n ? r1_addr : r0_addr;
      m_wdata = n ? r1_wdata : r0_wdata;
    end
  endtask

  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_gnt", {r0_gnt, r1_gnt}, 0);
    check("rst_done", {r0_done, r1_done}, 0);
    check("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    check("rst_mem_addr", mem_addr, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; mem_ack = 0;
    r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0; mem_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    #3;
    do_reset();
    // single refill read from r0, address changed mid-transfer
    r0_req = 1; r0_addr = 32'h1234;
    cycle();
    mem_ack = 1;
    for (int i = 0; i < BEATS; i++) begin
      mem_rdata = $urandom;
      if (i == 2) r0_addr = 32'hFFF0;
      cycle();
    end
    mem_ack = 0; r0_req = 0;
    cycle();
    cycle();
    // stray ack in idle
    mem_ack = 1;
    cycle();
    mem_ack = 0;
    cycle();
    // r1 write acked two cycles after mem_req
    r1_req = 1; r1_we = 1; r1_addr = 32'h80; r1_wdata = 32'hDEADBEEF;
    cycle();
    cycle();
    mem_ack = 1;
    cycle();
    mem_ack = 0; r1_req = 0;
    cycle();
    cycle();
    // tie of writes from reset
    do_reset();
    r0_req = 1; r1_req = 1; r0_we = 1; r1_we = 1; mem_ack = 1;
    for (int i = 0; i < 9; i++) cycle();
    // reset after the 2nd beat of a read, then restart from beat 0
    idle_inputs();
    cycle();
    cycle();
    r0_req = 1; r0_addr = 32'h400;
    cycle();
    mem_ack = 1;
    cycle();
    cycle();
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      r0_req    = $urandom_range(0, 9) < 6;
      r1_req    = $urandom_range(0, 9) < 6;
      r0_we     = $urandom_range(0, 1) == 1;
      r1_we     = $urandom_range(0, 1) == 1;
      r0_addr   = $urandom;
      r1_addr   = $urandom;
      r0_wdata  = $urandom;
      r1_wdata  = $urandom;
      mem_rdata = $urandom;
      mem_ack   = $urandom_range(0, 1) == 1;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter AW, default 32, meaning the byte address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data word width.
REQ-003 The block SHALL have parameter BEATS, default 4, meaning the words per read refill (power of two, at least 2).

Interface
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rN_req  input  1  for N=0,1: access request; N=0 is the icache, N=1 is the dcache.
REQ-007 rN_we  input  1  1 selects a single-word write, 0 selects a BEATS-word refill read.
REQ-008 rN_addr  input  AW  byte address of the access.
REQ-009 rN_wdata  input  DW  write data.
REQ-010 rN_gnt  output  1  high while requester N owns memory (ACCESS and RELEASE).
REQ-011 rN_rvalid  output  1  one-cycle pulse per refill word delivered to N.
REQ-012 rN_beat  output  log2(BEATS)  index of the word qualified by rN_rvalid.
REQ-013 rN_done  output  1  one-cycle pulse when N's transaction completes.
REQ-014 rdata  output  DW  shared read data, valid with rN_rvalid.
REQ-015 mem_req  output  1  memory access request.
REQ-016 mem_we  output  1  memory write strobe.
REQ-017 mem_addr  output  AW  memory byte address.
REQ-018 mem_wdata  output  DW  memory write data.
REQ-019 mem_rdata  input  DW  memory read data.
REQ-020 mem_ack  input  1  one-cycle pulse: current word written or read data valid.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RELEASE.
REQ-022 In IDLE with exactly one rN_req high, the block SHALL grant that N and enter ACCESS on the next edge.
REQ-023 In IDLE with both requests high, the block SHALL grant the requester not granted last (round-robin); the last-grant register resets to 1, so r0 wins the first tie.
REQ-024 On grant, the block SHALL register we, addr and wdata; later changes to rN_* inputs SHALL NOT affect the transaction in flight.
REQ-025 A requester dropping rN_req mid-transaction SHALL NOT abort the transaction; it completes normally.
REQ-026 mem_req SHALL be high in every ACCESS cycle and low otherwise; mem_we SHALL equal the registered we during ACCESS and be 0 otherwise.
REQ-027 For a write, mem_addr SHALL equal the registered addr; for a read, mem_addr = (addr with low log2(BEATS)+2 bits cleared) + 4*beat.
REQ-028 The beat counter SHALL reset to 0 on grant and increment on each mem_ack during a read.
REQ-029 During a read ACCESS, mem_ack SHALL produce a same-cycle (combinational) rN_rvalid to the granted N, with rN_beat = beat and rdata = mem_rdata.
REQ-030 A read mem_ack with beat = BEATS-1, or any write mem_ack, SHALL move the FSM to RELEASE; beat SHALL wrap to 0 after BEATS-1.
REQ-031 RELEASE SHALL last exactly one cycle with rN_done = 1 for the granted N, then return to IDLE.
REQ-032 A request is arbitrated no earlier than the cycle after RELEASE, giving the just-served requester one cycle to drop req.
REQ-033 mem_ack in IDLE or RELEASE SHALL be ignored: no rvalid, no state change.
REQ-034 The non-granted requester SHALL see gnt, rvalid and done all 0.
REQ-035 Minimum latency SHALL be: grant edge, then ACCESS with mem_ack in its first cycle, then RELEASE; this gives 3 cycles from req to done for a write.

Reset
REQ-036 While reset is high, regardless of clk: state = IDLE, beat = 0, last-grant = 1, and all outputs 0, including mem_req deasserting immediately.
REQ-037 Reset asserted mid-ACCESS SHALL abandon the transaction with no done pulse; after release, arbitration restarts from IDLE.

Verification
REQ-038 Single read: r0_req=1, r0_we=0, r0_addr=0x1234, BEATS=4, mem_ack on 4 consecutive cycles -> mem_addr 0x1230, 0x1234, 0x1238, 0x123C; r0_rvalid with beats 0..3; one r0_done pulse.
REQ-039 Tie: r0_req and r1_req both high from reset, both writes -> r0 served first, then r1, then r0 again if both are still requesting.
REQ-040 Write: r1_we=1, r1_addr=0x80, r1_wdata=0xDEADBEEF, mem_ack 2 cycles after mem_req -> mem_we=1, mem_addr=0x80, mem_wdata=0xDEADBEEF; r1_done 1 cycle after mem_ack.
REQ-041 Stray ack and input change: mem_ack pulsed in IDLE -> no rvalid or state change; changing r0_addr mid-read -> mem_addr unaffected.
REQ-042 Reset after the 2nd beat of a read -> mem_req=0 immediately, no r0_done; a new request afterwards starts at beat 0.
